// File: rtl/demuxer_unitary_router.sv
// Registered 1-to-NUM demultiplexer with valid/ready flow control; unselected slices read all-ones.
// Optional drop counter enabled by defining DEMUX_STAT_CNT_EN.
`timescale 1ns/1ps
module demuxer_unitary_router #(
  parameter int WIDTH = 8,
  parameter int NUM   = 4,
  localparam int AW   = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [AW-1:0]        addr_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [NUM*WIDTH-1:0] data_out_bus,
  output logic [NUM-1:0]       ena_out_bus,
  input  logic [NUM-1:0]       ready_in_bus,
  output logic                 addr_err
`ifdef DEMUX_STAT_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [NUM-1:0]   sel_q, sel_d;
  logic             err_q, err_d;

  logic [NUM-1:0]   addr_dec;
  logic             addr_ok;
  logic             hold;
  logic             take;
  logic             accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_dec
      assign addr_dec[gi] = (32'(addr_in) == gi);
    end
  endgenerate

  // Folds to constant 1 when NUM is a power of two.
  assign addr_ok = (32'(addr_in) < NUM);

  assign hold      = (state_q == HOLD);
  assign take      = hold && ((sel_q & ready_in_bus) != '0);
  assign ready_out = hold ? take : 1'b1;
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (addr_ok) begin
            data_d  = data_in;
            sel_d   = addr_dec;
            state_d = HOLD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (take) begin
          if (accept && addr_ok) begin
            data_d = data_in;
            sel_d  = addr_dec;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
          end
          if (accept && !addr_ok) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign addr_err    = err_q;
  assign ena_out_bus = hold ? sel_q : '0;

  // All-ones on idle slices lets a plain AND tree recombine the channels.
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_slice
      assign data_out_bus[gi*WIDTH +: WIDTH] = (hold && sel_q[gi]) ? data_q : {WIDTH{1'b1}};
    end
  endgenerate

`ifdef DEMUX_STAT_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (err_q && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
